// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment receive path: the active-low hex glyphs and segment bit positions.
// Segment vectors are {g,f,e,d,c,b,a}, which puts segment a in bit 0.
package seg_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex-to-segment decoder: active-low glyph in, nibble plus illegal flag out.
// Zero latency, no flow control; anything that is not one of the 16 glyphs decodes to 0 with illegal set.
module seg7_to_hex
   import seg_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [3:0] nibble,
   output logic       illegal
);

   always_comb begin
      nibble  = 4'h0;
      illegal = 1'b0;
      case (seg_n)
         GLYPH_0: nibble = 4'h0;
         GLYPH_1: nibble = 4'h1;
         GLYPH_2: nibble = 4'h2;
         GLYPH_3: nibble = 4'h3;
         GLYPH_4: nibble = 4'h4;
         GLYPH_5: nibble = 4'h5;
         GLYPH_6: nibble = 4'h6;
         GLYPH_7: nibble = 4'h7;
         GLYPH_8: nibble = 4'h8;
         GLYPH_9: nibble = 4'h9;
         GLYPH_A: nibble = 4'hA;
         GLYPH_B: nibble = 4'hB;
         GLYPH_C: nibble = 4'hC;
         GLYPH_D: nibble = 4'hD;
         GLYPH_E: nibble = 4'hE;
         GLYPH_F: nibble = 4'hF;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_capture.sv
// Recovers hex frames from a multiplexed active-low 7-seg bus; frame out one clock after the last digit capture.
// Output held while valid && !ready; a frame completing then is dropped and flags sticky overrun. SEG_CAPTURE_DP_EN adds dp.
module seg_capture
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   dig_n,
`ifdef SEG_CAPTURE_DP_EN
   input  logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   dp_out,
`endif
   output logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   err_mask,
   output logic                    valid,
   input  logic                    ready,
   output logic                    overrun
);

   localparam int            CW       = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
   localparam int            SW       = 7 + NUM_DIGITS + 1;

   logic                    dp_s;
   logic [SW-1:0]           sample;
   logic [SW-1:0]           prev;
   logic [NUM_DIGITS-1:0]   dig_sel;
   logic                    one_low;
   logic                    qual;
   logic                    same;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           cnt_next;
   logic                    capture;
   logic [NUM_DIGITS-1:0]   cap_mask;
   logic [3:0]              nib;
   logic                    illegal;
   logic [4*NUM_DIGITS-1:0] slot_val;
   logic [NUM_DIGITS-1:0]   slot_err;
   logic [NUM_DIGITS-1:0]   fresh;
   logic                    frame_done;

`ifdef SEG_CAPTURE_DP_EN
   logic [NUM_DIGITS-1:0]   slot_dp;
   assign dp_s = dp_n;
`else
   assign dp_s = 1'b1;
`endif

   seg7_to_hex u_dec (
      .seg_n   (seg_n),
      .nibble  (nib),
      .illegal (illegal)
   );

   // dp takes part in the compare so a dp edge restarts the dwell like any segment change
   assign sample  = {dp_s, seg_n, dig_n};
   assign dig_sel = ~dig_n;
   assign one_low = (dig_sel != '0) && ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
   assign qual    = one_low && (seg_n != SEG_BLANK);
   assign same    = (sample == prev);

   always_comb begin
      cnt_next = '0;
      capture  = 1'b0;
      if (qual) begin
         if (!same)
            cnt_next = CW'(1);
         else if (cnt == STABLE_C)
            cnt_next = cnt;
         else
            cnt_next = cnt + CW'(1);
         // a saturated, unchanged dwell must not fire again
         capture = (cnt_next == STABLE_C) && !(same && (cnt == STABLE_C));
      end
   end

   assign cap_mask   = capture ? dig_sel : '0;
   assign frame_done = &fresh;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev     <= '0;
         cnt      <= '0;
         slot_val <= '0;
         slot_err <= '0;
         fresh    <= '0;
         value    <= '0;
         err_mask <= '0;
         valid    <= 1'b0;
         overrun  <= 1'b0;
`ifdef SEG_CAPTURE_DP_EN
         slot_dp  <= '0;
         dp_out   <= '0;
`endif
      end else begin
         prev <= sample;
         cnt  <= cnt_next;

         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_mask[i]) begin
               slot_val[4*i +: 4] <= nib;
               slot_err[i]        <= illegal;
`ifdef SEG_CAPTURE_DP_EN
               slot_dp[i]         <= ~dp_n;
`endif
            end
         end

         // a capture landing on the hand-off edge belongs to the next frame
         fresh <= (frame_done ? '0 : fresh) | cap_mask;

         if (frame_done) begin
            if (!valid || ready) begin
               value    <= slot_val;
               err_mask <= slot_err;
               valid    <= 1'b1;
`ifdef SEG_CAPTURE_DP_EN
               dp_out   <= slot_dp;
`endif
            end else begin
               overrun <= 1'b1;
            end
         end else if (ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: inputs change on the falling edge, outputs are checked on the falling edge.
module tb_seg_capture;

   logic        clock = 1'b0;
   logic        reset;
   logic [6:0]  seg_n;
   logic [3:0]  dig_n;
   logic [15:0] value;
   logic [3:0]  err_mask;
   logic        valid;
   logic        ready;
   logic        overrun;
`ifdef SEG_CAPTURE_DP_EN
   logic        dp_n;
   logic [3:0]  dp_out;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clock    (clock),
      .reset    (reset),
      .seg_n    (seg_n),
      .dig_n    (dig_n),
`ifdef SEG_CAPTURE_DP_EN
      .dp_n     (dp_n),
      .dp_out   (dp_out),
`endif
      .value    (value),
      .err_mask (err_mask),
      .valid    (valid),
      .ready    (ready),
      .overrun  (overrun)
   );

   task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
      repeat (n) begin
         seg_n = s;
         dig_n = d;
         @(negedge clock);
      end
   endtask

   task automatic idle(input int n);
      drive(7'h7F, 4'hF, n);
   endtask

   task automatic dig(input int i, input logic [6:0] s);
      logic [3:0] d;
      d = ~(4'b0001 << i);
      drive(s, d, 4);
   endtask

   task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
      dig(0, s0);
      dig(1, s1);
      dig(2, s2);
      dig(3, s3);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      ready = 1'b1;
      seg_n = 7'h7F;
      dig_n = 4'hF;
`ifdef SEG_CAPTURE_DP_EN
      dp_n  = 1'b1;
`endif
      @(negedge clock);
      checks++; if (value !== 16'h0000) begin errors++; $display("FAIL reset_value: got %h expected 0000", value); end
      checks++; if (err_mask !== 4'h0) begin errors++; $display("FAIL reset_err: got %b expected 0000", err_mask); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_basic;
      frame(7'h24, 7'h19, 7'h06, 7'h79);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_latency: got valid %b expected 0 at capture edge", valid); end
      idle(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", valid); end
      checks++; if (value !== 16'h1E42) begin errors++; $display("FAIL basic_value: got %h expected 1e42", value); end
      checks++; if (err_mask !== 4'h0) begin errors++; $display("FAIL basic_err: got %b expected 0000", err_mask); end
      idle(1);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b expected 0", valid); end
   endtask

   task automatic test_glitch;
      drive(7'h24, 4'b1110, 3);
      idle(1);
      drive(7'h24, 4'b1110, 1);
      drive(7'h19, 4'b1110, 3);
      dig(1, 7'h19);
      dig(2, 7'h06);
      dig(3, 7'h79);
      idle(1);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL glitch_no_capture: got valid %b expected 0", valid); end
      dig(0, 7'h30);
      idle(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL glitch_recover_valid: got %b expected 1", valid); end
      checks++; if (value !== 16'h1E43) begin errors++; $display("FAIL glitch_value: got %h expected 1e43", value); end
      idle(1);
   endtask

   task automatic test_illegal;
      frame(7'h24, 7'h19, 7'h7E, 7'h79);
      idle(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL illegal_valid: got %b expected 1", valid); end
      checks++; if (value !== 16'h1042) begin errors++; $display("FAIL illegal_value: got %h expected 1042", value); end
      checks++; if (err_mask !== 4'b0100) begin errors++; $display("FAIL illegal_err: got %b expected 0100", err_mask); end
      idle(1);
   endtask

   task automatic test_bad_strobes;
      drive(7'h24, 4'b1100, 6);
      drive(7'h24, 4'b1111, 6);
      drive(7'h7F, 4'b1110, 6);
      drive(7'h24, 4'b1110, 3);
      drive(7'h24, 4'b1100, 1);
      drive(7'h24, 4'b1110, 3);
      dig(1, 7'h19);
      dig(2, 7'h06);
      dig(3, 7'h79);
      idle(1);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL strobe_no_capture: got valid %b expected 0", valid); end
      dig(0, 7'h12);
      idle(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL strobe_recover_valid: got %b expected 1", valid); end
      checks++; if (value !== 16'h1E45) begin errors++; $display("FAIL strobe_value: got %h expected 1e45", value); end
      idle(1);
   endtask

   task automatic test_single_dwell;
      dig(0, 7'h24);
      dig(1, 7'h19);
      dig(2, 7'h06);
      drive(7'h79, 4'b0111, 12);
      dig(0, 7'h24);
      dig(1, 7'h19);
      dig(2, 7'h06);
      idle(1);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL dwell_recapture: got valid %b expected 0", valid); end
      dig(3, 7'h79);
      idle(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL dwell_frame_valid: got %b expected 1", valid); end
      idle(1);
   endtask

   task automatic test_backpressure;
      ready = 1'b0;
      frame(7'h40, 7'h79, 7'h24, 7'h30);
      idle(1);
      checks++; if (value !== 16'h3210) begin errors++; $display("FAIL bp_frame1: got %h expected 3210", value); end
      idle(3);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_early_overrun: got %b expected 0", overrun); end
      frame(7'h19, 7'h12, 7'h02, 7'h78);
      idle(1);
      checks++; if (value !== 16'h3210) begin errors++; $display("FAIL bp_held_value: got %h expected 3210", value); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
      ready = 1'b1;
      idle(1);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_accept: got valid %b expected 0", valid); end
      frame(7'h00, 7'h10, 7'h08, 7'h03);
      idle(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_frame3_valid: got %b expected 1", valid); end
      checks++; if (value !== 16'hBA98) begin errors++; $display("FAIL bp_frame3_value: got %h expected ba98", value); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_sticky: got %b expected 1", overrun); end
      idle(1);
   endtask

   task automatic test_back_to_back;
      ready = 1'b0;
      frame(7'h46, 7'h21, 7'h06, 7'h0E);
      idle(1);
      checks++; if (value !== 16'hFEDC) begin errors++; $display("FAIL b2b_first: got %h expected fedc", value); end
      frame(7'h40, 7'h79, 7'h24, 7'h30);
      ready = 1'b1;
      idle(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_kept: got %b expected 1", valid); end
      checks++; if (value !== 16'h3210) begin errors++; $display("FAIL b2b_second: got %h expected 3210", value); end
      idle(1);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b expected 0", valid); end
   endtask

   task automatic test_reset_mid;
      dig(0, 7'h24);
      dig(1, 7'h19);
      dig(2, 7'h06);
      drive(7'h79, 4'b0111, 2);
      #2 reset = 1'b1;
      #1;
      checks++; if (value !== 16'h0000) begin errors++; $display("FAIL rst_mid_value: got %h expected 0000", value); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun: got %b expected 0", overrun); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", valid); end
      @(negedge clock);
      reset = 1'b0;
      dig(3, 7'h79);
      idle(1);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_partial: got valid %b expected 0", valid); end
      dig(0, 7'h24);
      dig(1, 7'h19);
      dig(2, 7'h06);
      idle(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rst_new_frame_valid: got %b expected 1", valid); end
      checks++; if (value !== 16'h1E42) begin errors++; $display("FAIL rst_new_frame_value: got %h expected 1e42", value); end
      idle(1);
   endtask

`ifdef SEG_CAPTURE_DP_EN
   task automatic test_dp;
      dig(0, 7'h24);
      dp_n = 1'b0;
      dig(1, 7'h19);
      dp_n = 1'b1;
      dig(2, 7'h06);
      dig(3, 7'h79);
      idle(1);
      checks++; if (dp_out !== 4'b0010) begin errors++; $display("FAIL dp_out: got %b expected 0010", dp_out); end
      checks++; if (err_mask !== 4'b0000) begin errors++; $display("FAIL dp_err: got %b expected 0000", err_mask); end
      idle(1);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_illegal();
      test_bad_strobes();
      test_single_dwell();
      test_backpressure();
      test_back_to_back();
`ifdef SEG_CAPTURE_DP_EN
      test_dp();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Receive end of the multiplexed 7-segment display path: samples active-low segment lines and active-low digit strobes, and recovers one hex nibble per digit.
- Assembles the nibbles of a full scan frame into a word, reports per-digit decode errors, and hands the frame out on a valid/ready interface.
- Used on self-check benches and board loopback: display driver output in, hex word out.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 4, consecutive identical samples needed before a digit is captured (>=1)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
seg_n  in  7  segment lines, active-low; bit0=a, bit1=b … bit6=g
dig_n  in  NUM_DIGITS  digit strobes, active-low; bit i selects digit i (slot i = value[4i+3:4i])
value  out  4*NUM_DIGITS  captured frame
err_mask  out  NUM_DIGITS  bit i set = digit i pattern was not a legal hex glyph
valid  out  1  frame available
ready  in  1  consumer accepts frame when valid&&ready
overrun  out  1  sticky: a completed frame was dropped because the output was still held

Behaviour:
- Reset values: value=0, err_mask=0, valid=0, overrun=0, stability counter=0, fresh mask=0, slot registers=0.
- Inputs are sampled as-is; the bench or top level supplies synchronised inputs.
- Sample qualifier: exactly one bit of dig_n is low, and seg_n != 7'h7F (blank). Otherwise the stability counter clears and no capture occurs.
- Stability counter:
  - Increments while {seg_n, dig_n} equals the previous cycle's value and the sample qualifies.
  - Clears on any change; the changed cycle counts as sample 1.
  - On the cycle the count reaches STABLE_CYCLES, the digit is captured; the counter then saturates.
  - A single dwell captures exactly once.
- Capture into slot i:
  - Decoded nibble is written to slot i and fresh[i] is set.
  - err_slot[i] = pattern illegal; nibble stored as 0 when illegal.
  - Re-capturing an already-fresh slot overwrites it.
- Legal glyphs, seg_n as hex {g..a}, for digits 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E. Every other pattern is illegal.
- Frame complete when fresh is all ones (including a capture in the current cycle). On the next clock:
  - If valid==0 or (valid&&ready): value/err_mask load from the slots, valid=1, fresh clears.
  - Else: the frame is dropped, overrun=1 (sticky until reset), fresh clears, and the held output is unchanged.
- Handshake:
  - value, err_mask and valid are stable while valid&&!ready.
  - valid drops the cycle after acceptance unless a new frame loads that same edge; back-to-back frames are allowed.
- Latency: the final digit's capture edge plus 1 clock until valid.
- Reset mid-frame discards partial captures; there is no partial-frame output.

Optional Feature:
- SEG_CAPTURE_DP_EN defined:
  - Adds input dp_n (1, active-low) and output dp_out (NUM_DIGITS).
  - dp_n joins the stability compare and is captured per slot.
  - dp_out loads with value and is held under the same handshake rules.
  - dp_n does not affect glyph legality.
- Undefined: no dp ports, and behaviour is otherwise identical.

Decomposition:
- Package seg_pkg: the 16 glyph constants, SEG_BLANK=7'h7F, and the segment bit-index constants.
- Sub-module seg7_to_hex: combinational, seg_n[6:0] -> nibble[3:0] plus illegal flag; the exact inverse of the team's hex-to-segment decoder.
- Everything else lives in seg_capture.

Test Plan:
- Reset: assert reset mid-capture -> all outputs 0 immediately (asynchronous); no valid after release until a full new frame arrives.
- Basic frame:
  - Stimulus: STABLE_CYCLES=4; dig0 gets 7'h24 for 4 cycles, then dig1 7'h19, dig2 7'h06, dig3 7'h79; ready=1.
  - Response: value=16'h1E42, err_mask=0, valid for exactly 1 cycle, 1 clock after the dig3 capture.
- Short dwell/glitch: dig0 held only 3 cycles, or seg changed at cycle 2 -> no capture; a fresh 4-cycle dwell then captures.
- Illegal glyph: dig2 = 7'h7E with the other digits legal -> err_mask=4'b0100, nibble 2 = 0.
- Backpressure:
  - Stimulus: ready=0 while frame 1 valid, then frame 2 completes.
  - Response: value holds frame 1, overrun=1; after ready=1 the frame 1 handshake completes and frame 3 is delivered normally.
- Bad strobes: dig_n=4'b1100 or 4'b1111, or seg blank -> no capture, counter clears; with SEG_CAPTURE_DP_EN, dp_n=0 on dig1 -> dp_out=4'b0010.
